// File: rtl/dll_pkg.sv
// Shared Data Link Layer encodings: DLCM states, FC DLLP types and InitFC phases.
package dll_pkg;

  typedef enum logic [1:0] {
    DLCM_INACTIVE = 2'd0,
    DLCM_INIT1    = 2'd1,
    DLCM_INIT2    = 2'd2,
    DLCM_ACTIVE   = 2'd3
  } dlcm_state_e;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } fc_type_e;

  typedef enum logic {
    PHASE_INITFC1 = 1'b0,
    PHASE_INITFC2 = 1'b1
  } initfc_phase_e;

  localparam int unsigned HDRFC_W  = 8;
  localparam int unsigned DATAFC_W = 12;

endpackage

// File: rtl/dll_fc_resend_timer.sv
// Loadable down-counter timing the idle gap between InitFC triplets.
module dll_fc_resend_timer #(
  parameter int unsigned RESEND_CYCLES = 16
) (
  input  logic sclk,
  input  logic srst,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(RESEND_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RESEND_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge sclk) begin
    if (srst)
      cnt <= '0;
    else if (load_i)
      cnt <= LOAD_VAL;
    else if (dec_i && cnt != '0)
      cnt <= cnt - CNT_W'(1);
  end

  assign expired_o = (cnt == '0);

endmodule

// File: rtl/dll_fc_init_sched.sv
// Flow-control initialisation scheduler: sends InitFC1/InitFC2 triplets during
// DLCM INIT1/INIT2, records peer credits and signals INIT1/INIT2 completion.
module dll_fc_init_sched
  import dll_pkg::*;
#(
  parameter logic [HDRFC_W-1:0]  P_HDR_FC      = 8'd32,
  parameter logic [DATAFC_W-1:0] P_DATA_FC     = 12'd256,
  parameter logic [HDRFC_W-1:0]  NP_HDR_FC     = 8'd32,
  parameter logic [DATAFC_W-1:0] NP_DATA_FC    = 12'd0,
  parameter logic [HDRFC_W-1:0]  CPL_HDR_FC    = 8'd0,
  parameter logic [DATAFC_W-1:0] CPL_DATA_FC   = 12'd0,
  parameter int unsigned         RESEND_CYCLES = 16
) (
  input  logic                sclk,
  input  logic                srst,
  input  logic [1:0]          DLCM_state_i,
  input  logic                rx_initfc1_vld_i,
  input  logic                rx_initfc2_vld_i,
  input  logic                rx_updatefc_vld_i,
  input  logic [1:0]          rx_fc_type_i,
  input  logic [HDRFC_W-1:0]  rx_hdrfc_i,
  input  logic [DATAFC_W-1:0] rx_datafc_i,
  output logic                tx_dllp_vld_o,
  input  logic                tx_dllp_rdy_i,
  output logic                tx_dllp_phase_o,
  output logic [1:0]          tx_fc_type_o,
  output logic [HDRFC_W-1:0]  tx_hdrfc_o,
  output logic [DATAFC_W-1:0] tx_datafc_o,
  output logic                init1_end_o,
  output logic                init2_end_o,
  output logic [HDRFC_W-1:0]  peer_p_hdrfc_o,
  output logic [DATAFC_W-1:0] peer_p_datafc_o,
  output logic [HDRFC_W-1:0]  peer_np_hdrfc_o,
  output logic [DATAFC_W-1:0] peer_np_datafc_o,
  output logic [HDRFC_W-1:0]  peer_cpl_hdrfc_o,
  output logic [DATAFC_W-1:0] peer_cpl_datafc_o
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_HOLD} state_e;

  state_e        state;
  fc_type_e      idx;
  fc_type_e      load_type;
  initfc_phase_e phase;
  logic [2:0]    seen;
  logic          fi2;
  logic          in_init, inactive, done, hs, phase_left;
  logic          tmr_load, tmr_dec, tmr_expired;

  function automatic logic [HDRFC_W-1:0] hdr_credit(input fc_type_e t);
    case (t)
      FC_P:    return P_HDR_FC;
      FC_NP:   return NP_HDR_FC;
      default: return CPL_HDR_FC;
    endcase
  endfunction

  function automatic logic [DATAFC_W-1:0] data_credit(input fc_type_e t);
    case (t)
      FC_P:    return P_DATA_FC;
      FC_NP:   return NP_DATA_FC;
      default: return CPL_DATA_FC;
    endcase
  endfunction

  assign inactive   = (DLCM_state_i == DLCM_INACTIVE);
  assign in_init    = (DLCM_state_i == DLCM_INIT1) || (DLCM_state_i == DLCM_INIT2);
  assign done       = (phase == PHASE_INITFC2) ? fi2 : &seen;
  assign hs         = tx_dllp_vld_o && tx_dllp_rdy_i;
  assign phase_left = (phase == PHASE_INITFC2) ? (DLCM_state_i != DLCM_INIT2)
                                               : (DLCM_state_i != DLCM_INIT1);
  assign tmr_load   = !inactive && (state == S_SEND) && hs && (idx == FC_CPL) && !done;
  assign tmr_dec    = (state == S_WAIT);

  // Type of the next request to present: restart at P, or step within the triplet.
  always_comb begin
    load_type = FC_P;
    if (state == S_SEND)
      load_type = (idx == FC_P) ? FC_NP : FC_CPL;
  end

  dll_fc_resend_timer #(
    .RESEND_CYCLES(RESEND_CYCLES)
  ) u_timer (
    .sclk     (sclk),
    .srst     (srst),
    .load_i   (tmr_load),
    .dec_i    (tmr_dec),
    .expired_o(tmr_expired)
  );

  always_ff @(posedge sclk) begin
    if (srst || inactive) begin
      seen              <= '0;
      fi2               <= 1'b0;
      peer_p_hdrfc_o    <= '0;
      peer_p_datafc_o   <= '0;
      peer_np_hdrfc_o   <= '0;
      peer_np_datafc_o  <= '0;
      peer_cpl_hdrfc_o  <= '0;
      peer_cpl_datafc_o <= '0;
    end else begin
      // Only the first InitFC1 per type in INIT1 is recorded.
      if (DLCM_state_i == DLCM_INIT1 && rx_initfc1_vld_i) begin
        case (rx_fc_type_i)
          FC_P: if (!seen[0]) begin
            seen[0]         <= 1'b1;
            peer_p_hdrfc_o  <= rx_hdrfc_i;
            peer_p_datafc_o <= rx_datafc_i;
          end
          FC_NP: if (!seen[1]) begin
            seen[1]          <= 1'b1;
            peer_np_hdrfc_o  <= rx_hdrfc_i;
            peer_np_datafc_o <= rx_datafc_i;
          end
          FC_CPL: if (!seen[2]) begin
            seen[2]           <= 1'b1;
            peer_cpl_hdrfc_o  <= rx_hdrfc_i;
            peer_cpl_datafc_o <= rx_datafc_i;
          end
          default: ;
        endcase
      end
      if (DLCM_state_i == DLCM_INIT2 && (rx_initfc2_vld_i || rx_updatefc_vld_i))
        fi2 <= 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (srst) begin
      state           <= S_IDLE;
      idx             <= FC_P;
      phase           <= PHASE_INITFC1;
      tx_dllp_vld_o   <= 1'b0;
      tx_dllp_phase_o <= 1'b0;
      tx_fc_type_o    <= '0;
      tx_hdrfc_o      <= '0;
      tx_datafc_o     <= '0;
      init1_end_o     <= 1'b0;
      init2_end_o     <= 1'b0;
    end else begin
      init1_end_o <= 1'b0;
      init2_end_o <= 1'b0;
      if (inactive) begin
        state         <= S_IDLE;
        idx           <= FC_P;
        tx_dllp_vld_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (in_init) begin
            phase           <= (DLCM_state_i == DLCM_INIT2) ? PHASE_INITFC2 : PHASE_INITFC1;
            tx_dllp_phase_o <= (DLCM_state_i == DLCM_INIT2);
            idx             <= load_type;
            tx_fc_type_o    <= load_type;
            tx_hdrfc_o      <= hdr_credit(load_type);
            tx_datafc_o     <= data_credit(load_type);
            tx_dllp_vld_o   <= 1'b1;
            state           <= S_SEND;
          end
          S_SEND: if (hs) begin
            if (idx != FC_CPL) begin
              idx          <= load_type;
              tx_fc_type_o <= load_type;
              tx_hdrfc_o   <= hdr_credit(load_type);
              tx_datafc_o  <= data_credit(load_type);
            end else begin
              tx_dllp_vld_o <= 1'b0;
              if (done) begin
                state       <= S_HOLD;
                init1_end_o <= (phase == PHASE_INITFC1);
                init2_end_o <= (phase == PHASE_INITFC2);
              end else begin
                state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            if (done) begin
              state       <= S_HOLD;
              init1_end_o <= (phase == PHASE_INITFC1);
              init2_end_o <= (phase == PHASE_INITFC2);
            end else if (tmr_expired) begin
              idx           <= load_type;
              tx_fc_type_o  <= load_type;
              tx_hdrfc_o    <= hdr_credit(load_type);
              tx_datafc_o   <= data_credit(load_type);
              tx_dllp_vld_o <= 1'b1;
              state         <= S_SEND;
            end
          end
          S_HOLD: if (phase_left)
            state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dll_fc_init_sched.sv
// Directed bench for dll_fc_init_sched: triplet sequencing, gaps, stalls,
// peer credit capture and INIT1/INIT2 completion pulses.
module tb_dll_fc_init_sched;
  import dll_pkg::*;

  logic        sclk = 1'b0;
  logic        srst;
  logic [1:0]  dlcm;
  logic        rx1_vld, rx2_vld, rxu_vld;
  logic [1:0]  rx_type;
  logic [7:0]  rx_hdr;
  logic [11:0] rx_data;
  logic        rdy;
  logic        vld, tx_phase;
  logic [1:0]  tx_type;
  logic [7:0]  tx_hdr;
  logic [11:0] tx_data;
  logic        end1, end2;
  logic [7:0]  p_hdr, np_hdr, cpl_hdr;
  logic [11:0] p_data, np_data, cpl_data;

  typedef struct packed {
    logic        phase;
    logic [1:0]  t;
    logic [7:0]  hdr;
    logic [11:0] data;
    logic [31:0] cyc;
  } hs_t;

  hs_t         hs_log[$];
  int unsigned cyc = 0;
  int unsigned n_p1 = 0, n_p2 = 0, p1_cyc = 0, p2_cyc = 0;
  int unsigned n_cmp = 0, n_err = 0;

  always #5 sclk = ~sclk;

  dll_fc_init_sched #(
    .RESEND_CYCLES(16)
  ) dut (
    .sclk             (sclk),
    .srst             (srst),
    .DLCM_state_i     (dlcm),
    .rx_initfc1_vld_i (rx1_vld),
    .rx_initfc2_vld_i (rx2_vld),
    .rx_updatefc_vld_i(rxu_vld),
    .rx_fc_type_i     (rx_type),
    .rx_hdrfc_i       (rx_hdr),
    .rx_datafc_i      (rx_data),
    .tx_dllp_vld_o    (vld),
    .tx_dllp_rdy_i    (rdy),
    .tx_dllp_phase_o  (tx_phase),
    .tx_fc_type_o     (tx_type),
    .tx_hdrfc_o       (tx_hdr),
    .tx_datafc_o      (tx_data),
    .init1_end_o      (end1),
    .init2_end_o      (end2),
    .peer_p_hdrfc_o   (p_hdr),
    .peer_p_datafc_o  (p_data),
    .peer_np_hdrfc_o  (np_hdr),
    .peer_np_datafc_o (np_data),
    .peer_cpl_hdrfc_o (cpl_hdr),
    .peer_cpl_datafc_o(cpl_data)
  );

  always @(posedge sclk) cyc <= cyc + 1;

  // Handshakes and end pulses, observed mid-cycle.
  always @(negedge sclk) begin
    if (vld && rdy)
      hs_log.push_back('{tx_phase, tx_type, tx_hdr, tx_data, cyc});
    if (end1) begin n_p1++; p1_cyc = cyc; end
    if (end2) begin n_p2++; p2_cyc = cyc; end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input logic ph, input logic [1:0] t,
                                     input logic [7:0] h, input logic [11:0] d);
    return {9'd0, ph, t, h, d};
  endfunction

  function automatic logic [31:0] ent(input int unsigned i);
    hs_t e;
    e = (i < hs_log.size()) ? hs_log[i] : '0;
    return {9'd0, e.phase, e.t, e.hdr, e.data};
  endfunction

  function automatic logic [31:0] ent_cyc(input int unsigned i);
    return (i < hs_log.size()) ? hs_log[i].cyc : 32'hffff_ffff;
  endfunction

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  task automatic rx1(input logic [1:0] t, input logic [7:0] h, input logic [11:0] d);
    rx1_vld = 1'b1; rx_type = t; rx_hdr = h; rx_data = d;
    step();
    rx1_vld = 1'b0;
  endtask

  task automatic wait_vld_type(input logic [1:0] t, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (vld && tx_type == t) found = 1'b1;
      else step();
    end
    chk(tag, 32'(found), 1);
  endtask

  task automatic wait_log(input int unsigned n, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (hs_log.size() >= n) found = 1'b1;
      else step();
    end
    chk(tag, 32'(found), 1);
  endtask

  initial begin
    int unsigned base, base2, b1, b2, s;
    logic        stable;

    srst = 1'b1; dlcm = 2'd0; rdy = 1'b1;
    rx1_vld = 1'b0; rx2_vld = 1'b0; rxu_vld = 1'b0;
    rx_type = 2'd0; rx_hdr = 8'd0; rx_data = 12'd0;
    repeat (3) step();
    chk("rst_vld", 32'(vld), 0);
    chk("rst_ends", 32'({end1, end2}), 0);
    chk("rst_tx", 32'({tx_phase, tx_type, tx_hdr, tx_data}), 0);
    chk("rst_peer_p", 32'({p_hdr, p_data}), 0);
    chk("rst_peer_np", 32'({np_hdr, np_data}), 0);
    chk("rst_peer_cpl", 32'({cpl_hdr, cpl_data}), 0);
    srst = 1'b0;
    step();

    // INIT1 with all peer InitFC1s during the first triplet
    base = hs_log.size(); b1 = n_p1;
    dlcm = 2'd1;
    rx1(2'd0, 8'h11, 12'h123);
    rx1(2'd1, 8'h22, 12'h045);
    rx1(2'd2, 8'h33, 12'h067);
    repeat (6) step();
    chk("a_count", 32'(hs_log.size() - base), 3);
    chk("a_p", ent(base), pk(1'b0, 2'd0, 8'd32, 12'd256));
    chk("a_np", ent(base + 1), pk(1'b0, 2'd1, 8'd32, 12'd0));
    chk("a_cpl", ent(base + 2), pk(1'b0, 2'd2, 8'd0, 12'd0));
    chk("a_pulses", 32'(n_p1 - b1), 1);
    chk("a_pulse_cyc", 32'(p1_cyc), ent_cyc(base + 2) + 1);
    chk("a_vld_hold", 32'(vld), 0);
    chk("a_peer_p", 32'({p_hdr, p_data}), 32'({8'h11, 12'h123}));
    chk("a_peer_np", 32'({np_hdr, np_data}), 32'({8'h22, 12'h045}));
    chk("a_peer_cpl", 32'({cpl_hdr, cpl_data}), 32'({8'h33, 12'h067}));

    // INIT2: stray InitFC1 ignored, UpdateFC mid-triplet
    base = hs_log.size(); b1 = n_p1; b2 = n_p2;
    dlcm = 2'd2;
    rx1(2'd0, 8'h99, 12'hfff);
    wait_vld_type(2'd1, "b_np_wait");
    rxu_vld = 1'b1; rx_type = 2'd0;
    step();
    rxu_vld = 1'b0;
    repeat (6) step();
    chk("b_count", 32'(hs_log.size() - base), 3);
    chk("b_p", ent(base), pk(1'b1, 2'd0, 8'd32, 12'd256));
    chk("b_np", ent(base + 1), pk(1'b1, 2'd1, 8'd32, 12'd0));
    chk("b_cpl", ent(base + 2), pk(1'b1, 2'd2, 8'd0, 12'd0));
    chk("b_pulses2", 32'(n_p2 - b2), 1);
    chk("b_pulse_cyc", 32'(p2_cyc), ent_cyc(base + 2) + 1);
    chk("b_no_pulse1", 32'(n_p1 - b1), 0);
    chk("b_peer_p_kept", 32'({p_hdr, p_data}), 32'({8'h11, 12'h123}));

    // INACTIVE clears; INIT1 without peers repeats with 16-cycle gaps
    dlcm = 2'd0;
    repeat (2) step();
    chk("c_peer_clr", 32'({p_hdr, p_data}), 0);
    chk("c_vld", 32'(vld), 0);
    base = hs_log.size(); b1 = n_p1;
    dlcm = 2'd1;
    wait_log(base + 9, "c_nine_wait");
    for (int i = 0; i < 9; i++)
      chk($sformatf("c_type%0d", i), 32'(ent(base + i) >> 20), 32'(i % 3));
    chk("c_gap1", ent_cyc(base + 3) - ent_cyc(base + 2), 17);
    chk("c_gap2", ent_cyc(base + 6) - ent_cyc(base + 5), 17);
    chk("c_no_pulse", 32'(n_p1 - b1), 0);
    rx1(2'd0, 8'd10, 12'd1);
    rx1(2'd0, 8'd20, 12'd2);
    rx1(2'd1, 8'd30, 12'd3);
    s = cyc;
    rx1(2'd2, 8'd40, 12'd4);
    repeat (25) step();
    chk("c_no_more_vld", 32'(hs_log.size() - base), 9);
    chk("c_pulse", 32'(n_p1 - b1), 1);
    chk("c_pulse_cyc", 32'(p1_cyc), s + 2);
    chk("c_peer_p_first", 32'({p_hdr, p_data}), 32'({8'd10, 12'd1}));

    // rdy stall on NP, then INACTIVE during the gap and a fresh restart
    dlcm = 2'd0;
    repeat (2) step();
    base = hs_log.size();
    dlcm = 2'd1;
    rx1(2'd0, 8'h55, 12'h555);
    wait_vld_type(2'd1, "d_np_wait");
    rdy = 1'b0;
    stable = 1'b1;
    repeat (5) begin
      step();
      if (!(vld && tx_type == 2'd1 && tx_hdr == 8'd32 && tx_data == 12'd0)) stable = 1'b0;
    end
    chk("d_np_stable", 32'(stable), 1);
    rdy = 1'b1;
    wait_log(base + 3, "d_three_wait");
    chk("d_count", 32'(hs_log.size() - base), 3);
    chk("d_p", ent(base), pk(1'b0, 2'd0, 8'd32, 12'd256));
    chk("d_np", ent(base + 1), pk(1'b0, 2'd1, 8'd32, 12'd0));
    chk("d_cpl", ent(base + 2), pk(1'b0, 2'd2, 8'd0, 12'd0));
    chk("d_np_delay", ent_cyc(base + 1) - ent_cyc(base), 6);
    chk("d_peer_p", 32'({p_hdr, p_data}), 32'({8'h55, 12'h555}));
    repeat (3) step();
    dlcm = 2'd0;
    step();
    dlcm = 2'd1;
    chk("d_peer_clr", 32'({p_hdr, p_data}), 0);
    chk("d_vld_clr", 32'(vld), 0);
    base2 = hs_log.size(); b1 = n_p1;
    rx1(2'd1, 8'h66, 12'h066);
    rx1(2'd2, 8'h77, 12'h077);
    wait_log(base2 + 3, "d_restart_wait");
    chk("d_restart_p", ent(base2), pk(1'b0, 2'd0, 8'd32, 12'd256));
    repeat (5) step();
    chk("d_seen_cleared", 32'(n_p1 - b1), 0);

    // srst while a request is stalled
    rdy = 1'b0;
    wait_vld_type(2'd0, "e_p_wait");
    srst = 1'b1;
    step();
    chk("e_vld_drop", 32'(vld), 0);
    chk("e_peer_np_clr", 32'({np_hdr, np_data}), 0);
    chk("e_ends", 32'({end1, end2}), 0);
    srst = 1'b0; dlcm = 2'd0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
